// File: rtl/raw10_frame_monitor_pkg.sv
// Shared definitions for the RAW10 frame monitor.
//   - mon_state_e : measurement FSM state encoding
//   - CNT_W_DEF   : default width of the pixel, line and frame counters
//   - sat_inc     : saturating increment, used for the pixel and line counters
package raw10_frame_monitor_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_HBLANK = 2'd2,
    ST_LINE   = 2'd3
  } mon_state_e;

  // Operates on a 32-bit container so that any counter width up to 32 bits
  // can share it. The caller passes its own all-ones value as max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/raw10_frame_monitor_if.sv
// Pixel bus bundle: frame valid, line valid and pixel data.
//   master : drives the bus (fv, lv, pixdata are outputs)
//   slave  : receives the bus (fv, lv, pixdata are inputs)
interface raw10_frame_monitor_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  fv;
  logic                  lv;
  logic [DATA_WIDTH-1:0] pixdata;

  modport master (output fv, lv, pixdata);
  modport slave  (input  fv, lv, pixdata);
endinterface

// File: rtl/raw10_mon_edge.sv
// One-cycle registered copy of the pixel bus plus fv/lv edge detection.
// Ports:
//   clk, rstn            : pixel clock, asynchronous active-low reset
//   fv_i, lv_i, pixdata_i: incoming pixel bus
//   fv_o, lv_o, pixdata_o: the same bus delayed by one clock
//   fv_rise_o, fv_fall_o : fv_i differs from its previous-cycle value (rise/fall)
//   lv_fall_o            : lv_i dropped relative to its previous-cycle value
module raw10_mon_edge #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fv_i,
  input  logic                  lv_i,
  input  logic [DATA_WIDTH-1:0] pixdata_i,
  output logic                  fv_o,
  output logic                  lv_o,
  output logic [DATA_WIDTH-1:0] pixdata_o,
  output logic                  fv_rise_o,
  output logic                  fv_fall_o,
  output logic                  lv_fall_o
);

  logic                  fv_q, fv_d;
  logic                  lv_q, lv_d;
  logic [DATA_WIDTH-1:0] pixdata_q, pixdata_d;

  always_comb begin
    fv_d      = fv_i;
    lv_d      = lv_i;
    pixdata_d = pixdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      pixdata_q <= '0;
    end else begin
      fv_q      <= fv_d;
      lv_q      <= lv_d;
      pixdata_q <= pixdata_d;
    end
  end

  assign fv_o      = fv_q;
  assign lv_o      = lv_q;
  assign pixdata_o = pixdata_q;

  assign fv_rise_o = fv_i & ~fv_q;
  assign fv_fall_o = ~fv_i & fv_q;
  assign lv_fall_o = ~lv_i & lv_q;

endmodule

// File: rtl/raw10_frame_monitor.sv
// RAW10 pixel-domain frame monitor.
// Passes the pixel bus through with one cycle of latency, measures pixels per
// line, lines per frame and completed frames, and raises sticky error flags
// when the geometry or the fv/lv nesting is wrong.
// Ports:
//   clk, rstn    : pixel clock, asynchronous active-low reset
//   pix_in       : pixel bus from the converter (fv, lv, pixdata)
//   pix_out      : pixel bus delayed one cycle
//   clear_i      : clears the sticky error flags (a same-cycle set wins)
//   line_len_o   : length of the last completed line
//   line_cnt_o   : line count of the last completed frame
//   frame_cnt_o  : number of completed frames, wraps
//   meas_valid_o : one-cycle pulse when a frame completes
//   err_len_o    : sticky, a line length differed from EXP_PIXELS
//   err_lines_o  : sticky, a frame line count differed from EXP_LINES
//   err_sync_o   : sticky, lv high while fv low, or fv fell with lv high
module raw10_frame_monitor
  import raw10_frame_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PIXELS = 1280,
  parameter int EXP_LINES  = 720
) (
  input  logic                         clk,
  input  logic                         rstn,
  raw10_frame_monitor_if.slave         pix_in,
  raw10_frame_monitor_if.master        pix_out,
  input  logic                         clear_i,
  output logic [CNT_W-1:0]             line_len_o,
  output logic [CNT_W-1:0]             line_cnt_o,
  output logic [CNT_W-1:0]             frame_cnt_o,
  output logic                         meas_valid_o,
  output logic                         err_len_o,
  output logic                         err_lines_o,
  output logic                         err_sync_o
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [31:0]      CNT_MAX  = 32'(CNT_ONES);
  localparam logic [CNT_W-1:0] EXP_PIX  = CNT_W'(EXP_PIXELS);
  localparam logic [CNT_W-1:0] EXP_LN   = CNT_W'(EXP_LINES);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), CNT_MAX));
  endfunction

  logic fv_rise, fv_fall, lv_fall;

  raw10_mon_edge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_edge (
    .clk       (clk),
    .rstn      (rstn),
    .fv_i      (pix_in.fv),
    .lv_i      (pix_in.lv),
    .pixdata_i (pix_in.pixdata),
    .fv_o      (pix_out.fv),
    .lv_o      (pix_out.lv),
    .pixdata_o (pix_out.pixdata),
    .fv_rise_o (fv_rise),
    .fv_fall_o (fv_fall),
    .lv_fall_o (lv_fall)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_len_q, err_len_d;
  logic             err_lines_q, err_lines_d;
  logic             err_sync_q, err_sync_d;

  logic             line_end, frame_end;
  logic             set_len, set_lines, set_sync;
  logic [CNT_W-1:0] lines_total;

  // VBLANK is only held while fv was low, and HBLANK/LINE only while fv was
  // high, so inside those states fv_rise/fv_fall reduce to the level of fv_i.
  // LINE is only held while lv was high, so lv_fall there means lv_i is low.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    meas_valid_d  = 1'b0;
    line_end      = 1'b0;
    frame_end     = 1'b0;
    set_len       = 1'b0;
    set_lines     = 1'b0;
    set_sync      = 1'b0;
    lines_total   = line_cnt_q;

    unique case (state_q)
      ST_SYNC: begin
        if (!pix_in.fv) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (fv_rise) begin
          state_d    = ST_HBLANK;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
        end else if (pix_in.lv) begin
          set_sync = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (fv_fall) begin
          frame_end = 1'b1;
          set_sync  = pix_in.lv;
        end else if (pix_in.lv) begin
          state_d   = ST_LINE;
          pix_cnt_d = CNT_W'(1);
        end
      end
      ST_LINE: begin
        if (lv_fall || fv_fall) begin
          line_end = 1'b1;
          if (fv_fall) begin
            frame_end = 1'b1;
            set_sync  = pix_in.lv;
          end else begin
            state_d = ST_HBLANK;
          end
        end else begin
          pix_cnt_d = cnt_inc(pix_cnt_q);
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // A line ending on the same edge as the frame is included in the total.
    if (line_end) begin
      line_len_d  = pix_cnt_q;
      lines_total = cnt_inc(line_cnt_q);
      line_cnt_d  = lines_total;
      if ((EXP_PIXELS != 0) && (pix_cnt_q != EXP_PIX)) set_len = 1'b1;
    end

    if (frame_end) begin
      state_d       = ST_VBLANK;
      frame_lines_d = lines_total;
      frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      meas_valid_d  = 1'b1;
      if ((EXP_LINES != 0) && (lines_total != EXP_LN)) set_lines = 1'b1;
    end

    err_len_d   = set_len   | (err_len_q   & ~clear_i);
    err_lines_d = set_lines | (err_lines_q & ~clear_i);
    err_sync_d  = set_sync  | (err_sync_q  & ~clear_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_SYNC;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      meas_valid_q  <= 1'b0;
      err_len_q     <= 1'b0;
      err_lines_q   <= 1'b0;
      err_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      meas_valid_q  <= meas_valid_d;
      err_len_q     <= err_len_d;
      err_lines_q   <= err_lines_d;
      err_sync_q    <= err_sync_d;
    end
  end

  assign line_len_o   = line_len_q;
  assign line_cnt_o   = frame_lines_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign meas_valid_o = meas_valid_q;
  assign err_len_o    = err_len_q;
  assign err_lines_o  = err_lines_q;
  assign err_sync_o   = err_sync_q;

endmodule

// File: tb/tb_raw10_frame_monitor.sv
// Testbench for raw10_frame_monitor, built with a 4-bit counter width so that
// saturation and frame-count wrap are reachable in a short run.
module tb_raw10_frame_monitor;

  localparam int DW      = 10;
  localparam int CW      = 4;
  localparam int EXP_PIX = 8;
  localparam int EXP_LN  = 4;
  localparam int CMAX    = 15;

  logic clk = 1'b0;
  logic rstn;
  logic clear;

  raw10_frame_monitor_if #(.DATA_WIDTH(DW)) in_if ();
  raw10_frame_monitor_if #(.DATA_WIDTH(DW)) out_if ();

  logic [CW-1:0] line_len, line_cnt, frame_cnt;
  logic          meas_valid, err_len, err_lines, err_sync;

  raw10_frame_monitor #(
    .DATA_WIDTH (DW),
    .CNT_W      (CW),
    .EXP_PIXELS (EXP_PIX),
    .EXP_LINES  (EXP_LN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pix_in       (in_if),
    .pix_out      (out_if),
    .clear_i      (clear),
    .line_len_o   (line_len),
    .line_cnt_o   (line_cnt),
    .frame_cnt_o  (frame_cnt),
    .meas_valid_o (meas_valid),
    .err_len_o    (err_len),
    .err_lines_o  (err_lines),
    .err_sync_o   (err_sync)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          pulses = 0;
  logic [9:0]  pix_pat = '0;
  int          lens[16];

  // Frame-level reference model state
  int          e_line_len  = 0;
  int          e_line_cnt  = 0;
  int          e_frame_cnt = 0;
  bit          e_len = 0, e_lines = 0, e_sync = 0;

  logic            pt_en = 1'b0;
  logic [DW+1:0]   pt_exp;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Expected passthrough value: whatever the inputs were at the previous edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pt_exp <= '0;
    else       pt_exp <= {in_if.fv, in_if.lv, in_if.pixdata};
  end

  always @(negedge clk) begin
    if (pt_en) checkOutput("passthrough", {out_if.fv, out_if.lv, out_if.pixdata}, pt_exp);
    if (rstn && meas_valid) pulses++;
  end

  task automatic applyStimulus(input logic fv, input logic lv, input logic clr);
    in_if.fv      = fv;
    in_if.lv      = lv;
    in_if.pixdata = pix_pat;
    pix_pat       = pix_pat + 10'd1;
    clear         = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag, input int pulse_delta, input int exp_pulses);
    checkOutput({tag, "_line_len"},  line_len,  e_line_len);
    checkOutput({tag, "_line_cnt"},  line_cnt,  e_line_cnt);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, e_frame_cnt);
    checkOutput({tag, "_err_len"},   err_len,   e_len);
    checkOutput({tag, "_err_lines"}, err_lines, e_lines);
    checkOutput({tag, "_err_sync"},  err_sync,  e_sync);
    checkOutput({tag, "_pulses"},    pulse_delta, exp_pulses);
  endtask

  // endMode 0: lv falls, fv falls later in HBLANK
  // endMode 1: fv and lv fall on the same cycle
  // endMode 2: fv falls while lv is still high
  // clearLine: index of the line whose end cycle also carries clear (-1: none)
  task automatic sendFrame(input string tag, input int nlines, input int endMode,
                           input int clearLine);
    int p0 = pulses;
    repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 1'b0, 1'b0);
    if (nlines == 0) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < nlines; k++) begin
      bit last = (k == nlines - 1);
      repeat (lens[k]) applyStimulus(1'b1, 1'b1, 1'b0);
      if (last && endMode == 2)      applyStimulus(1'b0, 1'b1, clearLine == k);
      else if (last && endMode == 1) applyStimulus(1'b0, 1'b0, clearLine == k);
      else                           applyStimulus(1'b1, 1'b0, clearLine == k);
      checkOutput({tag, "_line_len_mid"}, line_len, sat(lens[k]));
      if (last && endMode == 0) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
      end else if (!last) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 1'b0);
      end
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < nlines; k++) begin
      if (clearLine == k) begin
        e_len = 0; e_lines = 0; e_sync = 0;
      end
      e_line_len = sat(lens[k]);
      if (e_line_len != EXP_PIX) e_len = 1;
    end
    e_line_cnt  = sat(nlines);
    e_frame_cnt = (e_frame_cnt + 1) % 16;
    if (e_line_cnt != EXP_LN) e_lines = 1;
    if (endMode == 2 && nlines > 0) e_sync = 1;
    checkModel(tag, pulses - p0, 1);
  endtask

  task automatic sendClear();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    e_len = 0; e_lines = 0; e_sync = 0;
    checkOutput("clear_err_len",   err_len,   1'b0);
    checkOutput("clear_err_lines", err_lines, 1'b0);
    checkOutput("clear_err_sync",  err_sync,  1'b0);
  endtask

  task automatic fillLens(input int n, input int len);
    for (int k = 0; k < 16; k++) lens[k] = (k < n) ? len : 0;
  endtask

  initial begin
    int p0;
    int nl, mode, cl, sel;
    rstn = 1'b1;
    clear = 1'b0;
    in_if.fv = 1'b1;
    in_if.lv = 1'b0;
    in_if.pixdata = '0;
    #2 rstn = 1'b0;
    pt_en = 1'b1;
    #10;
    $display("[TB] checking reset state");
    checkModel("reset", 0, 0);
    checkOutput("reset_pt", {out_if.fv, out_if.lv, out_if.pixdata}, 12'h000);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Partial frame already in progress at reset release is ignored
    p0 = pulses;
    repeat (3) begin
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkModel("partial", pulses - p0, 0);

    fillLens(4, 8);
    sendFrame("good", 4, 0, -1);

    fillLens(4, 8);
    lens[1] = 7;
    sendFrame("short_line", 4, 0, -1);
    fillLens(4, 8);
    sendFrame("sticky_len", 4, 1, -1);

    fillLens(5, 8);
    sendFrame("five_lines", 5, 0, -1);

    fillLens(4, 8);
    lens[1] = 6;
    sendFrame("clear_vs_set", 4, 0, 1);

    sendClear();
    fillLens(4, 8);
    lens[3] = 6;
    sendFrame("fv_drop_lv_high", 4, 2, -1);

    sendClear();
    p0 = pulses;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    e_sync = 1;
    checkModel("vblank_lv", pulses - p0, 0);

    fillLens(0, 0);
    sendFrame("no_lines", 0, 0, -1);

    fillLens(4, 8);
    lens[2] = 20;
    sendFrame("saturate", 4, 0, -1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 6) sendClear();
      nl = $urandom_range(1, 6);
      for (int k = 0; k < 16; k++)
        lens[k] = ($urandom_range(0, 3) != 0) ? EXP_PIX : $urandom_range(1, 20);
      sel  = $urandom_range(0, 4);
      mode = (sel < 3) ? 0 : sel - 2;
      cl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      sendFrame("random", nl, mode, cl);
    end

    $display("[TB] frame counter wrap");
    fillLens(1, 2);
    for (int guard = 0; guard < 20 && e_frame_cnt != 15; guard++)
      sendFrame("short", 1, 0, -1);
    checkOutput("frame_pre_wrap", frame_cnt, 4'hF);
    sendFrame("wrap", 1, 0, -1);
    checkOutput("frame_wrap", frame_cnt, 4'h0);

    pt_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
